// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_FILLR = 3'b110,
    MODE_CLR   = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/usr_next_state.sv
// Combinational next-value function of the shift register for one operation.
// "Right" moves bits towards the MSB (HC194 convention), "left" towards the LSB.
module usr_next_state
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  mode_e              mode_i,
  input  logic [WIDTH-1:0]   q_i,
  input  logic [WIDTH-1:0]   d_i,
  input  logic               dsr_i,
  input  logic               dsl_i,
  output logic [WIDTH-1:0]   q_o
);

  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_HOLD:  q_o = q_i;
      MODE_SHR:   q_o = {q_i[WIDTH-2:0], dsr_i};
      MODE_SHL:   q_o = {dsl_i, q_i[WIDTH-1:1]};
      MODE_LOAD:  q_o = d_i;
      MODE_ROR:   q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROL:   q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_FILLR: q_o = {q_i[WIDTH-2:0], q_i[0]};
      MODE_CLR:   q_o = '0;
      default:    q_o = q_i;
    endcase
  end

endmodule

// File: rtl/uni_shift_reg.sv
// Parametrised universal shift register with immediate ops and a counted burst engine.
// A burst of CNT ops takes CNT enabled edges; DONE is a registered one-cycle pulse after the last.
module uni_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              EN,
  input  logic [2:0]        S,
  input  logic [WIDTH-1:0]  D,
  input  logic              DSR,
  input  logic              DSL,
  input  logic              START,
  input  logic [CW-1:0]     CNT,
  output logic [WIDTH-1:0]  Q,
  output logic              SOR,
  output logic              SOL,
  output logic              BUSY,
  output logic              DONE
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  mode_e            op_mode;
  logic [WIDTH-1:0] op_q;

  // In BURST the latched mode drives the datapath; S is only looked at while idle.
  assign op_mode = (state_q == ST_BURST) ? mode_q : mode_e'(S);

  usr_next_state #(.WIDTH(WIDTH)) u_next (
    .mode_i (op_mode),
    .q_i    (q_q),
    .d_i    (D),
    .dsr_i  (DSR),
    .dsl_i  (DSL),
    .q_o    (op_q)
  );

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (EN) begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            mode_d = mode_e'(S);
            if (CNT == '0) begin
              done_d = 1'b1;
            end else begin
              q_d   = op_q;
              cnt_d = CNT - CW'(1);
              if (CNT == CW'(1)) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_BURST;
              end
            end
          end else begin
            q_d = op_q;
          end
        end
        ST_BURST: begin
          q_d   = op_q;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Q    = q_q;
    SOR  = q_q[WIDTH-1];
    SOL  = q_q[0];
    BUSY = (state_q == ST_BURST);
    DONE = done_q;
  end

endmodule

// File: tb/tb_uni_shift_reg.sv
// Directed bench for uni_shift_reg: a 4-bit instance for HC194 compatibility and reset,
// an 8-bit instance for rotate/fill bursts, stalls, boundaries and abort.
module tb_uni_shift_reg;

  logic cp;
  logic mr;

  logic       en4, dsr4, dsl4, start4;
  logic [2:0] s4, cnt4;
  logic [3:0] d4, q4;
  logic       sor4, sol4, busy4, done4;

  logic       en8, dsr8, dsl8, start8;
  logic [2:0] s8;
  logic [3:0] cnt8;
  logic [7:0] d8, q8;
  logic       sor8, sol8, busy8, done8;

  int n_vec;
  int n_miss;

  uni_shift_reg #(.WIDTH(4)) u_dut4 (
    .CP(cp), .MR(mr), .EN(en4), .S(s4), .D(d4), .DSR(dsr4), .DSL(dsl4),
    .START(start4), .CNT(cnt4), .Q(q4), .SOR(sor4), .SOL(sol4),
    .BUSY(busy4), .DONE(done4)
  );

  uni_shift_reg #(.WIDTH(8)) u_dut8 (
    .CP(cp), .MR(mr), .EN(en8), .S(s8), .D(d8), .DSR(dsr8), .DSL(dsl8),
    .START(start8), .CNT(cnt8), .Q(q8), .SOR(sor8), .SOL(sol8),
    .BUSY(busy8), .DONE(done8)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs change there too.
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  // 8-bit status check: Q, BUSY, DONE.
  task automatic chk8(input string tag, input logic [7:0] q, input logic b, input logic d);
    chk({tag, ".q"}, 32'(q8), 32'(q));
    chk({tag, ".busy"}, 32'(busy8), 32'(b));
    chk({tag, ".done"}, 32'(done8), 32'(d));
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    mr = 1'b0;
    en4 = 1'b1; s4 = 3'b000; d4 = '0; dsr4 = 1'b0; dsl4 = 1'b0; start4 = 1'b0; cnt4 = '0;
    en8 = 1'b1; s8 = 3'b000; d8 = '0; dsr8 = 1'b0; dsl8 = 1'b0; start8 = 1'b0; cnt8 = '0;
    #1;
    chk("rst4.q", 32'(q4), 32'h0);
    chk("rst4.busy", 32'(busy4), 32'h0);
    chk("rst4.done", 32'(done4), 32'h0);
    chk8("rst8", 8'h00, 1'b0, 1'b0);
    #3 mr = 1'b1;

    // Load then asynchronous reset in mid-cycle.
    s4 = 3'b011; d4 = 4'b1011;
    tick();
    chk("load4", 32'(q4), 32'hB);
    chk("load4.sor", 32'(sor4), 32'h1);
    #2 mr = 1'b0;
    #1;
    chk("async_rst.q", 32'(q4), 32'h0);
    chk("async_rst.busy", 32'(busy4), 32'h0);
    mr = 1'b1;
    d4 = 4'b1111;
    tick();
    chk("load4_ones", 32'(q4), 32'hF);
    s4 = 3'b111;
    tick();
    chk("sync_clr", 32'(q4), 32'h0);

    // HC194-compatible shifts from 0000.
    s4 = 3'b001; dsr4 = 1'b1;
    tick(); chk("shr1", 32'(q4), 32'h1);
    tick(); chk("shr2", 32'(q4), 32'h3);
    tick(); chk("shr3", 32'(q4), 32'h7);
    chk("shr3.sor", 32'(sor4), 32'h0);
    s4 = 3'b010; dsl4 = 1'b0;
    tick(); chk("shl1", 32'(q4), 32'h3);
    chk("shl1.sol", 32'(sol4), 32'h1);
    s4 = 3'b000;
    tick(); tick(); chk("hold", 32'(q4), 32'h3);

    // Rotate-right burst of 3 on 0x81.
    s8 = 3'b011; d8 = 8'h81;
    tick(); chk8("ld81", 8'h81, 1'b0, 1'b0);
    s8 = 3'b100; cnt8 = 4'd3; start8 = 1'b1;
    tick(); chk8("ror.e1", 8'h03, 1'b1, 1'b0);
    s8 = 3'b000; start8 = 1'b0;
    tick(); chk8("ror.e2", 8'h06, 1'b1, 1'b0);
    tick(); chk8("ror.e3", 8'h0C, 1'b0, 1'b1);
    chk("ror.sor", 32'(sor8), 32'h0);
    tick(); chk8("ror.after", 8'h0C, 1'b0, 1'b0);

    // Rotate-left burst of 4 on 0xB4 with a 2-cycle stall and ignored toggles.
    s8 = 3'b011; d8 = 8'hB4;
    tick(); chk8("ldB4", 8'hB4, 1'b0, 1'b0);
    s8 = 3'b101; cnt8 = 4'd4; start8 = 1'b1;
    tick(); chk8("rol.e1", 8'h5A, 1'b1, 1'b0);
    s8 = 3'b011; d8 = 8'hFF; cnt8 = 4'd1; start8 = 1'b1;
    tick(); chk8("rol.e2", 8'h2D, 1'b1, 1'b0);
    en8 = 1'b0; start8 = 1'b0; s8 = 3'b111;
    tick(); chk8("rol.stall1", 8'h2D, 1'b1, 1'b0);
    start8 = 1'b1;
    tick(); chk8("rol.stall2", 8'h2D, 1'b1, 1'b0);
    en8 = 1'b1;
    tick(); chk8("rol.e3", 8'h96, 1'b1, 1'b0);
    s8 = 3'b000; start8 = 1'b0;
    tick(); chk8("rol.e4", 8'h4B, 1'b0, 1'b1);
    tick(); chk8("rol.after", 8'h4B, 1'b0, 1'b0);

    // CNT=0: no op, single DONE.
    s8 = 3'b011; d8 = 8'h00; cnt8 = 4'd0; start8 = 1'b1;
    tick(); chk8("cnt0", 8'h4B, 1'b0, 1'b1);
    s8 = 3'b000; start8 = 1'b0;
    tick(); chk8("cnt0.after", 8'h4B, 1'b0, 1'b0);

    // CNT=1: one shift-right op, no BUSY.
    s8 = 3'b001; dsr8 = 1'b1; cnt8 = 4'd1; start8 = 1'b1;
    tick(); chk8("cnt1", 8'h97, 1'b0, 1'b1);
    s8 = 3'b000; start8 = 1'b0;
    tick(); chk8("cnt1.after", 8'h97, 1'b0, 1'b0);

    // Fill-right burst of 3 on 0x01.
    s8 = 3'b011; d8 = 8'h01;
    tick(); chk8("ld01", 8'h01, 1'b0, 1'b0);
    s8 = 3'b110; cnt8 = 4'd3; start8 = 1'b1;
    tick(); chk8("fill.e1", 8'h03, 1'b1, 1'b0);
    s8 = 3'b000; start8 = 1'b0;
    tick(); chk8("fill.e2", 8'h07, 1'b1, 1'b0);
    tick(); chk8("fill.e3", 8'h0F, 1'b0, 1'b1);

    // Abort a burst with 5 ops remaining, then run a fresh burst.
    s8 = 3'b111;
    tick(); chk8("clr8", 8'h00, 1'b0, 1'b0);
    s8 = 3'b001; dsr8 = 1'b1; cnt8 = 4'd7; start8 = 1'b1;
    tick(); chk8("abort.e1", 8'h01, 1'b1, 1'b0);
    s8 = 3'b000; start8 = 1'b0;
    tick(); chk8("abort.e2", 8'h03, 1'b1, 1'b0);
    #2 mr = 1'b0;
    #1; chk8("abort.rst", 8'h00, 1'b0, 1'b0);
    tick(); chk8("abort.held", 8'h00, 1'b0, 1'b0);
    mr = 1'b1;
    tick(); chk8("abort.nodone", 8'h00, 1'b0, 1'b0);
    s8 = 3'b011; d8 = 8'h81;
    tick(); chk8("re.ld", 8'h81, 1'b0, 1'b0);
    s8 = 3'b100; cnt8 = 4'd2; start8 = 1'b1;
    tick(); chk8("re.e1", 8'h03, 1'b1, 1'b0);
    s8 = 3'b000; start8 = 1'b0;
    tick(); chk8("re.e2", 8'h06, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uni_shift_reg.md
Name: uni_shift_reg

Overview:
- Parametrised successor of the team's 4-bit bidirectional universal shift register.
- Adds configurable width, rotate, fill-extend and synchronous-clear modes, clock enable, and a counted burst engine that runs N operations autonomously with a BUSY/DONE handshake.
- Sits behind the glue-logic and mux blocks in the top-level, driving parallel and serial outputs to pads.

Parameters:
- WIDTH, 4, register length in bits (minimum 2).
- CW, $clog2(WIDTH+1), width of the burst count input; derived, not overridden.

Ports:
- CP  in  1  clock, rising edge.
- MR  in  1  asynchronous active-low reset.
- EN  in  1  clock enable. 0 stalls everything (immediate ops and burst counting).
- S  in  3  mode select (encoding below).
- D  in  WIDTH  parallel load data.
- DSR  in  1  serial input for right shift (enters Q[0]).
- DSL  in  1  serial input for left shift (enters Q[WIDTH-1]).
- START  in  1  launch a burst of CNT operations of mode S.
- CNT  in  CW  burst length.
- Q  out  WIDTH  register contents.
- SOR  out  1  right serial out, = Q[WIDTH-1].
- SOL  out  1  left serial out, = Q[0].
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: one clock, CP. Reset is asynchronous and active-low (MR). MR=0 forces immediately Q=0, BUSY=0, DONE=0, count=0, latched mode=000. This applies at any time, including mid-burst; the aborted burst produces no DONE.
- Mode encoding (S[2]=0 is HC194-compatible with S[1:0]):
  - 000 hold.
  - 001 shift right: Q[0]<=DSR, Q[i]<=Q[i-1].
  - 010 shift left: Q[WIDTH-1]<=DSL, Q[i]<=Q[i+1].
  - 011 parallel load: Q<=D.
  - 100 rotate right: Q[0]<=Q[WIDTH-1].
  - 101 rotate left: Q[WIDTH-1]<=Q[0].
  - 110 fill-right: like 001 but Q[0] keeps its value (extend).
  - 111 synchronous clear: Q<=0.
- Two FSM states: IDLE and BURST.
- IDLE, EN=1, START=0: execute S once per rising edge (immediate mode). EN=0: hold.
- IDLE, EN=1, START=1, CNT>0:
  - Latch S into mode register and CNT into count.
  - Execute the first operation on the same edge; count<=CNT-1.
  - If CNT=1: stay IDLE and pulse DONE next cycle.
  - Otherwise: go to BURST with BUSY=1.
- IDLE, EN=1, START=1, CNT=0: no operation, Q unchanged, DONE pulses for one cycle after the edge. BUSY stays 0.
- BURST, EN=1:
  - Execute latched mode, decrement count.
  - When count reaches 0 after the operation: return to IDLE, BUSY<=0, DONE<=1 for exactly one cycle.
- BURST, EN=0: Q, count and state frozen; BUSY stays 1; DONE does not fire.
- BURST: S, START, CNT are ignored. D, DSR and DSL are still sampled live each operation (load/shift use current values).
- Total burst latency: CNT enabled edges. DONE is registered and asserted in the cycle following the last operation edge.
- Next START is accepted in the DONE cycle (state is IDLE).
- SOR and SOL are combinational from Q; no extra latency.
- Count is never allowed to wrap. Any CNT value up to 2^CW-1 is legal; rotates beyond WIDTH simply wrap positionally.

Decomposition:
- Shared package usr_pkg: mode enum (MODE_HOLD..MODE_CLR, 3 bits), state enum (ST_IDLE, ST_BURST).
- One natural sub-module, usr_next_state: purely combinational, (mode, Q, D, DSR, DSL) -> next Q. It is reused by both immediate and burst paths.
- The FSM and counter stay in uni_shift_reg.

Test Plan:
- Reset and clear: WIDTH=4, load D=1011 (S=011), then assert MR=0 mid-cycle -> Q=0000 immediately, BUSY=0. Release MR, S=111 after loading 1111 -> Q=0000.
- HC194 compatibility: WIDTH=4, Q=0000.
  - S=001 with DSR=1 for 3 edges -> Q=0111, SOR=0.
  - Then S=010, DSL=0 for 1 edge -> Q=0011.
  - S=000 -> Q held.
- Rotate burst: WIDTH=8, load 0x81, START with S=100, CNT=3 -> BUSY high for 2 cycles after launch, Q=0x0C, DONE single pulse on 3rd cycle.
- Stall and ignore: WIDTH=8, burst S=101, CNT=4 with EN=0 for 2 cycles mid-burst and S/START toggled during BUSY -> final Q equals 4 left rotations of the start value. DONE appears 2 cycles later than the unstalled case; toggles have no effect.
- Boundaries:
  - CNT=0 -> Q unchanged, BUSY never high, DONE one pulse.
  - CNT=1 -> one op, BUSY never high, DONE one pulse.
  - Fill-right S=110 on 0x01, CNT=3 (WIDTH=8) -> Q=0x0F.
- Abort: MR=0 during BURST with count=5 -> Q=0, no DONE. A new START after reset runs a full burst normally.
